// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO peripheral: register word offsets and window base.
package gpio_pkg;

  localparam logic [2:0] GPIO_OFF_OUT      = 3'd0;
  localparam logic [2:0] GPIO_OFF_DIR      = 3'd1;
  localparam logic [2:0] GPIO_OFF_IN       = 3'd2;
  localparam logic [2:0] GPIO_OFF_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_OFF_IRQ_STAT = 3'd4;
  localparam logic [2:0] GPIO_OFF_EDGE_SEL = 3'd5;

  localparam logic [31:0] GPIO_BASE = 32'h0100_0000;

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser with one-cycle edge-history output.
// The prev flops exist only when GPIO_IRQ_EN is defined.
module gpio_sync #(
  parameter int unsigned NUM_PINS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_PINS-1:0] pad_in,
  output logic [NUM_PINS-1:0] sync,
  output logic [NUM_PINS-1:0] prev
);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] stage_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic [NUM_PINS-1:0] prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync;
    end
  end

  assign prev = prev_q;
`else
  assign prev = '0;
`endif

endmodule

// File: rtl/gpio_controller.sv
// Memory-mapped GPIO peripheral: OUT/DIR/IN registers, per-pin edge interrupts.
// Interrupt registers and irq are present only when GPIO_IRQ_EN is defined.
module gpio_controller
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned NUM_PINS     = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    gpio_read,
  input  logic                    gpio_write,
  input  logic [ADDRESS_BITS-1:0] gpio_address_in,
  input  logic [DATA_WIDTH-1:0]   gpio_data_in,
  output logic [DATA_WIDTH-1:0]   gpio_data_out,
  output logic [ADDRESS_BITS-1:0] gpio_address_out,
  output logic                    gpio_valid,
  output logic                    gpio_ready,
  input  logic [NUM_PINS-1:0]     pad_in,
  output logic [NUM_PINS-1:0]     pad_out,
  output logic [NUM_PINS-1:0]     pad_oe,
  output logic                    irq
);

  logic [2:0]          offset;
  logic [NUM_PINS-1:0] wdata;
  logic                wr_en;
  logic                rd_en;
  logic [NUM_PINS-1:0] sync;
  logic [NUM_PINS-1:0] prev;
  logic [NUM_PINS-1:0] out_q;
  logic [NUM_PINS-1:0] dir_q;
  logic [NUM_PINS-1:0] irq_en_q;
  logic [NUM_PINS-1:0] irq_stat_q;
  logic [NUM_PINS-1:0] edge_sel_q;
  logic [NUM_PINS-1:0] rdata_c;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic [ADDRESS_BITS-1:0] addr_out_q;
  logic                    valid_q;
  logic                    unused_data;

  assign offset      = gpio_address_in[4:2];
  assign wdata       = gpio_data_in[NUM_PINS-1:0];
  assign wr_en       = gpio_write;
  assign rd_en       = gpio_read & ~gpio_write;
  assign unused_data = ^gpio_data_in;

  gpio_sync #(
    .NUM_PINS   (NUM_PINS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .pad_in(pad_in),
    .sync  (sync),
    .prev  (prev)
  );

  // Register read mux; unmapped offsets read zero.
  always_comb begin
    rdata_c = '0;
    case (offset)
      GPIO_OFF_OUT:      rdata_c = out_q;
      GPIO_OFF_DIR:      rdata_c = dir_q;
      GPIO_OFF_IN:       rdata_c = sync;
      GPIO_OFF_IRQ_EN:   rdata_c = irq_en_q;
      GPIO_OFF_IRQ_STAT: rdata_c = irq_stat_q;
      GPIO_OFF_EDGE_SEL: rdata_c = edge_sel_q;
      default:           rdata_c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q      <= '0;
      dir_q      <= '0;
      data_out_q <= '0;
      addr_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (wr_en && offset == GPIO_OFF_OUT) out_q <= wdata;
      if (wr_en && offset == GPIO_OFF_DIR) dir_q <= wdata;
      valid_q <= rd_en;
      if (rd_en) begin
        data_out_q <= DATA_WIDTH'(rdata_c);
        addr_out_q <= gpio_address_in;
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NUM_PINS-1:0] event_c;
  logic [NUM_PINS-1:0] clr_c;
  logic                irq_q;

  assign event_c = ((edge_sel_q & sync & ~prev) | (~edge_sel_q & ~sync & prev)) & irq_en_q;
  assign clr_c   = (wr_en && offset == GPIO_OFF_IRQ_STAT) ? wdata : '0;

  // A same-cycle edge event overrides a W1C clear of that bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en && offset == GPIO_OFF_IRQ_EN)   irq_en_q   <= wdata;
      if (wr_en && offset == GPIO_OFF_EDGE_SEL) edge_sel_q <= wdata;
      irq_stat_q <= (irq_stat_q & ~clr_c) | event_c;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  assign irq = irq_q;
`else
  logic unused_prev;

  assign irq_en_q    = '0;
  assign edge_sel_q  = '0;
  assign irq_stat_q  = '0;
  assign irq         = 1'b0;
  assign unused_prev = ^prev;
`endif

  assign gpio_data_out    = data_out_q;
  assign gpio_address_out = addr_out_q;
  assign gpio_valid       = valid_q;
  assign gpio_ready       = ~reset;
  assign pad_out          = out_q;
  assign pad_oe           = dir_q;

endmodule
